// File: rtl/product_display_if.sv
// rtl/product_display_if.sv - product/scroll inputs and seven-segment outputs of product_display
interface product_display_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] product;
    logic              product_valid;
    logic              scroll_left;
    logic              scroll_right;
    logic              busy;
    logic [6:0]        seg;
    logic [3:0]        an;

    modport master (
        output product, product_valid, scroll_left, scroll_right,
        input  busy, seg, an
    );

    modport slave (
        input  product, product_valid, scroll_left, scroll_right,
        output busy, seg, an
    );
endinterface

// File: rtl/product_display.sv
// rtl/product_display.sv - signed product to 5-digit BCD (double-dabble) with scrollable 4-digit display
// Optional: LEADING_ZERO_BLANK_EN blanks leading zeros in the window (units digit always shown).
module product_display #(
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    product_display_if.slave   bus
);
    localparam int BCD_W = 20;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int ITR_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [ITR_W-1:0] ITR_MAX = ITR_W'(DATA_W - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;
    state_t state, state_next;

    logic [ITR_W-1:0]  iter;
    logic [DATA_W-1:0] mag_r;
    logic [BCD_W-1:0]  bcd_r;
    logic              sign_r;
    logic [BCD_W-1:0]  disp_bcd;
    logic              disp_sign;
    logic [1:0]        offset;
    logic [CNT_W-1:0]  refresh_cnt;
    logic [1:0]        sel;

    logic [DATA_W-1:0]       mag_in;
    logic                    sign_in;
    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W+DATA_W-1:0] shifted;
    logic                    last_iter;

    assign mag_in  = bus.product[DATA_W-1] ? (~bus.product + DATA_W'(1)) : bus.product;
    assign sign_in = bus.product[DATA_W-1] & (bus.product != '0);
    assign last_iter = (state == CONV) && (iter == ITR_MAX) && !bus.product_valid;

    always_comb begin
        bcd_adj = bcd_r;
        for (int i = 0; i < 5; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
        end
        shifted = {bcd_adj, mag_r} << 1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.product_valid) state_next = CONV;
            CONV: begin
                if (bus.product_valid)  state_next = CONV;
                else if (iter == ITR_MAX) state_next = SHOW;
            end
            SHOW: if (bus.product_valid) state_next = CONV;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy = (state == CONV);
    end

    // Conversion datapath; the display copy only moves on the final iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter      <= '0;
            mag_r     <= '0;
            bcd_r     <= '0;
            sign_r    <= 1'b0;
            disp_bcd  <= '0;
            disp_sign <= 1'b0;
        end else if (bus.product_valid) begin
            iter   <= '0;
            mag_r  <= mag_in;
            bcd_r  <= '0;
            sign_r <= sign_in;
        end else if (state == CONV) begin
            iter  <= iter + 1'b1;
            mag_r <= shifted[DATA_W-1:0];
            bcd_r <= shifted[BCD_W+DATA_W-1:DATA_W];
            if (last_iter) begin
                disp_bcd  <= shifted[BCD_W+DATA_W-1:DATA_W];
                disp_sign <= sign_r;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset <= 2'd0;
        end else if (bus.product_valid) begin
            offset <= 2'd0;
        end else if (bus.scroll_left && !bus.scroll_right) begin
            if (offset != 2'd2) offset <= offset + 2'd1;
        end else if (bus.scroll_right && !bus.scroll_left) begin
            if (offset != 2'd0) offset <= offset - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            sel         <= 2'd0;
        end else if (refresh_cnt == CNT_MAX) begin
            refresh_cnt <= '0;
            sel         <= sel + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // lead_zero[k]: digits d4..dk are all zero
    logic [4:0] lead_zero;
    always_comb begin
        lead_zero    = '0;
        lead_zero[4] = (disp_bcd[19:16] == 4'd0);
        for (int i = 3; i >= 1; i--)
            lead_zero[i] = lead_zero[i+1] & (disp_bcd[4*i +: 4] == 4'd0);
    end
`endif

    logic [2:0] digit_idx;
    logic [3:0] digit;
    logic [6:0] seg_next;

    always_comb begin
        digit_idx = 3'(offset) + 3'(sel);
        digit     = disp_bcd[{digit_idx, 2'b00} +: 4];
        seg_next  = SEG_BLANK;
        if (sel == 2'd3) begin
            seg_next = disp_sign ? SEG_MINUS : SEG_BLANK;
        end else begin
            seg_next = seg_code(digit);
`ifdef LEADING_ZERO_BLANK_EN
            if (lead_zero[digit_idx]) seg_next = SEG_BLANK;
`endif
        end
    end

    // seg and an share one register stage so they switch on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an  <= 4'b1111;
            bus.seg <= SEG_BLANK;
        end else begin
            bus.an  <= ~(4'b0001 << sel);
            bus.seg <= seg_next;
        end
    end
endmodule
